// File: rtl/axi_arbiter_rd_pkg.sv
// Shared definitions for the AXI read-channel arbiter.
//   state_t      : arbiter FSM states (address select / data wait)
//   MaxPorts     : widest request vector the helper function handles
//   round_robin(): next one-hot grant, strictly after the current grant,
//                  wrapping; current grant kept when nobody else requests
package axi_arbiter_rd_pkg;

  typedef enum logic [0:0] {
    SELECT    = 1'b0,
    WAIT_DATA = 1'b1
  } state_t;

  localparam int unsigned MaxPorts  = 32;
  localparam logic [1:0]  BurstIncr = 2'b01;

  function automatic logic [MaxPorts-1:0] round_robin(
    input logic [MaxPorts-1:0] req,
    input logic [MaxPorts-1:0] grant,
    input int unsigned         ports
  );
    logic [MaxPorts-1:0] next;
    int unsigned         cur;
    int unsigned         idx;
    logic                found;
    next  = grant;
    cur   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxPorts; i++) begin
      if (i < ports && grant[i[4:0]]) cur = i;
    end
    for (int unsigned k = 1; k < MaxPorts; k++) begin
      idx = (cur + k) % ports;
      if (k < ports && !found && req[idx[4:0]]) begin
        next           = '0;
        next[idx[4:0]] = 1'b1;
        found          = 1'b1;
      end
    end
    return next;
  endfunction

endpackage

// File: rtl/axi_arbiter_rd_stream_buf_v.sv
// stream_buf_v: single-register valid/ready pipeline stage.
// Adds one cycle of latency but keeps full throughput: it accepts a new
// word whenever it is empty or its current word leaves this cycle.
//   clk, rst            : clock, synchronous active-high reset (empties stage)
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data payload
module stream_buf_v #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_ready) out_data <= in_data;
  end

endmodule

// File: rtl/axi_arbiter_rd.sv
// axi_arbiter_rd: round-robin arbiter sharing one AXI slave's AR/R channels
// among Ports masters, one burst in flight at a time. The grant is held
// from AR accept until the R beat carrying rlast; the received beat count
// is checked against arlen.
//   clk, rst   : clock, synchronous active-high reset
//   slv_ar*    : per-port read address channels (packed, port n at slice n)
//   slv_r*     : per-port read data; data/resp broadcast, valid/last to the
//                granted port only, rid tied 0
//   mst_ar*    : master read address channel (optionally registered)
//   mst_r*     : master read data channel (mst_rid ignored)
//   len_err    : one-cycle pulse, registered (high in the cycle after the
//                offending beat): rlast count != arlen+1, or beat past arlen
module axi_arbiter_rd
  import axi_arbiter_rd_pkg::*;
#(
  parameter int unsigned Ports     = 2,
  parameter int unsigned DataBits  = 64,
  parameter int unsigned AddrBits  = 32,
  parameter int unsigned LenBits   = 4,
  parameter int unsigned OutBuffer = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [Ports-1:0]             slv_arvalid,
  output logic [Ports-1:0]             slv_arready,
  input  logic [Ports*AddrBits-1:0]    slv_araddr,
  input  logic [Ports*LenBits-1:0]     slv_arlen,
  output logic [Ports-1:0]             slv_rvalid,
  input  logic [Ports-1:0]             slv_rready,
  output logic [Ports-1:0]             slv_rlast,
  output logic [Ports*DataBits-1:0]    slv_rdata,
  output logic [Ports*2-1:0]           slv_rresp,
  output logic [Ports*4-1:0]           slv_rid,
  output logic                         mst_arvalid,
  input  logic                         mst_arready,
  output logic [AddrBits-1:0]          mst_araddr,
  output logic [LenBits-1:0]           mst_arlen,
  output logic [3:0]                   mst_arid,
  output logic [2:0]                   mst_arsize,
  output logic [1:0]                   mst_arburst,
  output logic [1:0]                   mst_arlock,
  input  logic                         mst_rvalid,
  output logic                         mst_rready,
  input  logic                         mst_rlast,
  input  logic [DataBits-1:0]          mst_rdata,
  input  logic [1:0]                   mst_rresp,
  input  logic [3:0]                   mst_rid,
  output logic                         len_err
);

  localparam int unsigned ArBits = AddrBits + LenBits;
  localparam logic [2:0]  ArSize = 3'($clog2(DataBits / 8));

  state_t               state;
  state_t               state_next;
  logic [Ports-1:0]     grant;
  logic [Ports-1:0]     grant_rr;
  logic [LenBits-1:0]   beat_cnt;
  logic [LenBits-1:0]   exp_len;
  logic [AddrBits-1:0]  araddr_sel;
  logic [LenBits-1:0]   arlen_sel;
  logic [MaxPorts-1:0]  req_ext;
  logic [MaxPorts-1:0]  grant_ext;
  logic                 arvalid_sel;
  logic                 rready_sel;
  logic                 ar_in_valid;
  logic                 ar_in_ready;
  logic                 ar_accept;
  logic                 r_beat;
  logic                 unused_rid;

  assign unused_rid = ^mst_rid;

  assign arvalid_sel = |(slv_arvalid & grant);
  assign rready_sel  = |(slv_rready & grant);
  assign ar_accept   = (state == SELECT) && arvalid_sel && ar_in_ready;
  assign r_beat      = (state == WAIT_DATA) && mst_rvalid && rready_sel;

  always_comb begin
    araddr_sel = '0;
    arlen_sel  = '0;
    for (int unsigned i = 0; i < Ports; i++) begin
      if (grant[i]) begin
        araddr_sel = slv_araddr[i*AddrBits +: AddrBits];
        arlen_sel  = slv_arlen[i*LenBits +: LenBits];
      end
    end
  end

  always_comb begin
    req_ext                = '0;
    grant_ext              = '0;
    req_ext[Ports-1:0]     = slv_arvalid;
    grant_ext[Ports-1:0]   = grant;
  end

  assign grant_rr = Ports'(round_robin(req_ext, grant_ext, Ports));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= SELECT;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      SELECT:    if (ar_accept)             state_next = WAIT_DATA;
      WAIT_DATA: if (r_beat && mst_rlast)   state_next = SELECT;
      default:                              state_next = SELECT;
    endcase
  end

  // Output logic. slv_arready is also qualified by the port's own arvalid,
  // so non-requesting ports never see ready and the reset state shows 0.
  always_comb begin
    ar_in_valid = 1'b0;
    slv_arready = '0;
    slv_rvalid  = '0;
    slv_rlast   = '0;
    mst_rready  = 1'b0;
    unique case (state)
      SELECT: begin
        ar_in_valid = arvalid_sel;
        slv_arready = grant & slv_arvalid & {Ports{ar_in_ready}};
      end
      WAIT_DATA: begin
        slv_rvalid = grant & {Ports{mst_rvalid}};
        slv_rlast  = grant & {Ports{mst_rlast}};
        mst_rready = rready_sel;
      end
      default: ;
    endcase
  end

  // Grant, burst length and beat tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      grant    <= {{(Ports-1){1'b0}}, 1'b1};
      beat_cnt <= '0;
      exp_len  <= '0;
      len_err  <= 1'b0;
    end else begin
      len_err <= 1'b0;
      unique case (state)
        SELECT: begin
          if (ar_accept) begin
            exp_len  <= arlen_sel;
            beat_cnt <= '0;
          end else if (!arvalid_sel) begin
            grant <= grant_rr;
          end
        end
        WAIT_DATA: begin
          if (r_beat) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (mst_rlast) begin
              len_err <= (beat_cnt != exp_len);
              grant   <= grant_rr;
            end else if (beat_cnt == exp_len) begin
              len_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  if (OutBuffer != 0) begin : g_ar_buf
    logic [ArBits-1:0] ar_out;
    stream_buf_v #(.Width(ArBits)) u_ar_buf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (ar_in_valid),
      .in_ready  (ar_in_ready),
      .in_data   ({araddr_sel, arlen_sel}),
      .out_valid (mst_arvalid),
      .out_ready (mst_arready),
      .out_data  (ar_out)
    );
    assign mst_araddr = ar_out[ArBits-1 -: AddrBits];
    assign mst_arlen  = ar_out[LenBits-1:0];
  end else begin : g_ar_direct
    assign mst_arvalid = ar_in_valid;
    assign ar_in_ready = mst_arready;
    assign mst_araddr  = araddr_sel;
    assign mst_arlen   = arlen_sel;
  end

  assign mst_arid    = '0;
  assign mst_arsize  = ArSize;
  assign mst_arburst = BurstIncr;
  assign mst_arlock  = '0;
  assign slv_rdata   = {Ports{mst_rdata}};
  assign slv_rresp   = {Ports{mst_rresp}};
  assign slv_rid     = '0;

endmodule
